// File: rtl/serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : serial_add_ctrl
// Purpose  : Bit-serial W-bit adder controller sharing one 1-bit full-adder
//            cell, LSB first, with sum/carry-out/signed-overflow results.
// Revision : 1.0 - initial release
// ============================================================================
module serial_add_ctrl #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a_in,
    input  logic [W-1:0] b_in,
    input  logic         cin,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] sum_out,
    output logic         cout,
    output logic         ovf
);

    localparam int            CW        = $clog2(W);
    localparam logic [CW-1:0] c_LAST    = CW'(W - 1);
    localparam logic [CW-1:0] c_PENULT  = CW'(W - 2);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]    r_state;
    logic [W-1:0]  r_sa;
    logic [W-1:0]  r_sb;
    logic [W-1:0]  r_ss;
    logic          r_cy;
    logic          r_cm;
    logic [CW-1:0] r_cnt;
    logic [W-1:0]  r_sum;
    logic          r_cout;
    logic          r_ovf;

    logic          w_s;
    logic          w_co;

    // The single shared full-adder cell.
    assign w_s  = r_sa[0] ^ r_sb[0] ^ r_cy;
    assign w_co = (r_sa[0] & r_sb[0]) | (r_sb[0] & r_cy) | (r_sa[0] & r_cy);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_sa    <= '0;
            r_sb    <= '0;
            r_ss    <= '0;
            r_cy    <= 1'b0;
            r_cm    <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE, c_DONE: begin
                    if (start) begin
                        r_sa    <= a_in;
                        r_sb    <= b_in;
                        r_cy    <= cin;
                        r_cnt   <= '0;
                        r_state <= c_RUN;
                    end else begin
                        r_state <= c_IDLE;
                    end
                end
                c_RUN: begin
                    r_ss  <= {w_s, r_ss[W-1:1]};
                    r_sa  <= r_sa >> 1;
                    r_sb  <= r_sb >> 1;
                    r_cy  <= w_co;
                    r_cnt <= r_cnt + CW'(1);
                    // Carry out of bit W-2 is the carry into the MSB.
                    if (r_cnt == c_PENULT) begin
                        r_cm <= w_co;
                    end
                    if (r_cnt == c_LAST) begin
                        r_sum   <= {w_s, r_ss[W-1:1]};
                        r_cout  <= w_co;
                        r_ovf   <= r_cm ^ w_co;
                        r_cnt   <= '0;
                        r_state <= c_DONE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign busy    = (r_state == c_RUN);
    assign done    = (r_state == c_DONE);
    assign sum_out = r_sum;
    assign cout    = r_cout;
    assign ovf     = r_ovf;

endmodule
`default_nettype wire

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Bit-serial adder controller that time-shares a single 1-bit full-adder cell to add two W-bit operands, LSB first, one bit per clock. It accepts a start request, sequences the cell through W bit slots with a registered carry, and returns the W-bit sum, carry-out and signed overflow with a one-cycle done pulse. It sits between a requesting datapath and the shared full-adder cell, trading area for latency.

## Interface
- W, 8: operand/result width in bits; legal range 2..32.
- clk  in  1  rising-edge clock, sole clock domain.
- rst  in  1  synchronous reset, active-high.
- start  in  1  request; sampled only when busy=0.
- a_in  in  W  operand A; latched on accepted start.
- b_in  in  W  operand B; latched on accepted start.
- cin  in  1  carry-in; latched on accepted start.
- busy  out  1  high while an addition is in progress.
- done  out  1  one-cycle pulse; result valid and updated in that cycle.
- sum_out  out  W  result, held until the next completion.
- cout  out  1  carry out of bit W-1, held with sum_out.
- ovf  out  1  signed overflow (carry into bit W-1 XOR carry out of bit W-1), held with sum_out.

## Operation
- One internal full-adder cell: s = a^b^c, co = ab | bc | ac. No second cell; all W bits pass through it serially.
- Internal state: shift registers sa, sb (W bits), sum shift register ss (W bits), carry flop cy, bit counter cnt (ceil(log2 W) bits), carry-into-MSB flop cm.
- FSM states: IDLE, RUN, DONE.
  - IDLE: busy=0, done=0. start=1 -> latch a_in->sa, b_in->sb, cin->cy, cnt=0; go RUN.
  - RUN: each cycle feed sa[0], sb[0], cy to the cell; shift ss right inserting s at bit W-1; shift sa, sb right; cy<=co; cnt<=cnt+1. When cnt=W-2, capture cy as cm (carry into MSB; for W=2 this is the carry out of bit 0). When cnt=W-1 (last bit): load sum_out with {s, ss[W-1:1]}, cout<=co, ovf<=cm^co, done<=1; go DONE.
  - DONE: busy=0, done=1 for this cycle only. start=1 -> accepted exactly as in IDLE, go RUN (back-to-back). Otherwise go IDLE.
- start while busy=1 is ignored; no queuing, no error flag.
- a_in, b_in, cin are don't-care except on the accepting edge; changes during RUN have no effect.
- sum_out, cout, ovf change only on the completion edge or on reset.
- Arithmetic: unsigned modulo 2^W for sum_out; {cout, sum_out} equals a+b+cin exactly.

## Timing
- Reset (rst=1 at a rising edge): state=IDLE, busy=0, done=0, sum_out=0, cout=0, ovf=0, cy=0, cnt=0, cm=0. Reset wins over start and over an in-progress operation; the partial result is discarded and outputs clear.
- Edge E0: start accepted. busy=1 after E0.
- Edges E1..EW: bit slots 0..W-1. The result registers update at EW; after EW, done=1 and busy=0.
- Edge EW+1: done returns to 0 unless a new completion occurs. A start sampled at EW+1 begins the next operation, with busy=1 after EW+1.
- Start-to-done latency is W edges (done visible in the cycle after EW). Maximum throughput is one addition per W+1 cycles.
- busy and done are never both 1.

## Test plan
- Reset, then W=8, a=0x5A, b=0x3C, cin=0, start for 1 cycle -> busy high 8 cycles, done pulse once, sum_out=0x96, cout=0, ovf=1.
- a=0xFF, b=0x01, cin=0 -> sum_out=0x00, cout=1, ovf=0. Then a=0x7F, b=0x00, cin=1 -> sum_out=0x80, cout=0, ovf=1.
- start held high continuously with a=0x10, b=0x20, then operands changed mid-RUN to 0xAA/0x55 -> first result 0x30; second op starts in the DONE cycle, result 0xFF, cout=0. Exactly 9 cycles between done pulses.
- start pulsed at RUN cycle 3 with different operands -> ignored; only one done pulse, and the result is from the original operands.
- rst asserted at RUN cycle 4 -> next cycle busy=0, done=0, sum_out=0, cout=0, ovf=0. No done pulse follows. A fresh start of 0x01+0x01 gives 0x02.
- Random sweep of 1000 operand/cin triples -> {cout, sum_out} equals a+b+cin, and ovf matches signed overflow, on every done.
